split_n: RTL and testbench
==========================

# split_n

Clocked, parametrised N-way packet splitter for the PE datapath. It joins one data channel with one select channel and routes each packet to one of NOUT output channels, or to all of them in broadcast mode. Every output has its own DEPTH-entry FIFO, so a stalled consumer only blocks packets addressed to it. Select values outside 0..NOUT-1 consume the packet, drop it and count it.

## Interface
Parameters:
- WIDTH, 8: packet width in bits.
- NOUT, 4: number of output channels, 2..16.
- DEPTH, 2: entries per output FIFO; power of two, at least 2.
- SELW, $clog2(NOUT): select width. Derived; do not override.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- l_valid  in  1  data packet offered.
- l_ready  out  1  data packet accepted this cycle.
- l_data  in  WIDTH  packet payload.
- s_valid  in  1  select token offered.
- s_ready  out  1  select token accepted this cycle; always equal to l_ready.
- s_sel  in  SELW  destination index.
- s_bcast  in  1  1 = send to all outputs; s_sel is then ignored.
- r_valid  out  NOUT  per-output data available.
- r_ready  in  NOUT  per-output consumer ready.
- r_data  out  NOUT*WIDTH  output i occupies bits [i*WIDTH +: WIDTH].
- drop_pulse  out  1  one-cycle pulse when a packet is dropped.
- drop_count  out  16  number of dropped packets; saturates at 16'hFFFF.

## Operation
- Join: a transfer needs l_valid and s_valid in the same cycle. Neither channel is consumed on its own.
- Space:
  - Unicast needs free space in FIFO[s_sel].
  - Broadcast needs free space in every FIFO.
  - Invalid select (s_bcast=0, s_sel>=NOUT) needs no space.
- Ready: l_ready = s_ready = l_valid & s_valid & space. This path is combinational from the valid inputs and registered FIFO counts only. It never depends on r_ready.
- Free space means the registered count is below DEPTH. A full FIFO does not accept a write in the same cycle it is popped.
- On a fire (l_ready=1):
  - Unicast writes l_data into FIFO[s_sel].
  - Broadcast writes l_data into all NOUT FIFOs in the same cycle.
  - Invalid select discards the packet. drop_pulse=1 on the next cycle and drop_count increments, saturating.
- Output side:
  - r_valid[i] = (count[i] != 0).
  - r_data slice i = head of FIFO[i].
  - A pop happens when r_valid[i] & r_ready[i].
  - Each output's FIFO order is arrival order.
- Each FIFO is a circular buffer with read and write pointers of log2(DEPTH) bits. The pointers wrap modulo DEPTH.
- count is $clog2(DEPTH)+1 bits wide. In the same cycle:
  - push and pop together leave count unchanged;
  - push alone adds 1;
  - pop alone subtracts 1.
- Outputs never interact. Back-pressure on output j never stalls a unicast to output k≠j. It does stall broadcasts.

## Timing
- Reset (rst_n low, taking effect immediately): all counts and pointers = 0, r_valid = 0, r_data = 0, drop_pulse = 0, drop_count = 0.
- While rst_n is low, l_ready = s_ready = 0.
- Reset in mid-operation discards every buffered packet.
- Latency: a packet accepted on edge t shows r_valid=1 in the cycle after edge t. That is one cycle; there is no combinational bypass.
- Throughput: one accepted packet per cycle while space holds. Each output can pop one per cycle. A FIFO that is popped every cycle, with DEPTH≥2, sustains one packet per cycle.
- drop_pulse is registered and asserts for exactly one cycle per drop. Back-to-back drops hold it high on consecutive cycles.
- r_data of an empty FIFO holds its last value. Consumers must qualify it with r_valid.
- r_valid and r_data stay stable until popped; no output is retracted.

## Test plan
- Reset: hold rst_n=0 with l_valid=s_valid=1 -> l_ready=0 and r_valid=0. Release reset, send 0xA5 to sel=2 -> r_valid=4'b0100 one cycle later, r_data slice 2 = 0xA5.
- Join: l_valid=1 with s_valid=0 for 5 cycles -> no accept. Raise s_valid (sel=1, packet 0x3C) -> accepted that cycle, appears on output 1 only.
- Isolation and full: r_ready[0]=0, then send 3 packets to output 0 (DEPTH=2) -> 2 accepted, 3rd stalls. A packet to output 3 in the meantime passes. Pulse r_ready[0] -> 3rd accepted the next cycle; order 1,2,3 preserved.
- Broadcast: s_bcast=1, packet 0x77 with all outputs empty -> all r_valid=1111, all slices 0x77. Repeat with FIFO 2 full -> no accept until output 2 pops.
- Drop: NOUT=3, sel=3 -> l_ready=1, no r_valid change, drop_pulse high one cycle, drop_count=1. Force drop_count to 16'hFFFE, then two more drops -> 16'hFFFF, stays saturated.
- Wrap: stream 20 packets (values 0..19) to output 1 with r_ready[1] toggled randomly -> output order 0..19, no loss or duplication; pointers wrap multiple times.

Source files
------------

// File: rtl/split_n_if.sv
// Bundle of the data, select and per-output result channels of split_n.
//
// Handshake rule for every channel below: a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer holds valid and
// its payload steady until the transfer. Ready never looks at the
// consumer-side r_ready. The data and select inputs are joined, so they
// transfer together.
interface split_n_if #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int SELW  = $clog2(NOUT)
);
  logic                    l_valid;
  logic                    l_ready;
  logic [WIDTH-1:0]        l_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [SELW-1:0]         s_sel;
  logic                    s_bcast;
  logic [NOUT-1:0]         r_valid;
  logic [NOUT-1:0]         r_ready;
  logic [NOUT*WIDTH-1:0]   r_data;

  // Splitter side.
  modport slave (
    input  l_valid, l_data, s_valid, s_sel, s_bcast, r_ready,
    output l_ready, s_ready, r_valid, r_data
  );

  // Producer/consumer side.
  modport master (
    output l_valid, l_data, s_valid, s_sel, s_bcast, r_ready,
    input  l_ready, s_ready, r_valid, r_data
  );
endinterface

// File: rtl/split_n.sv
// N-way packet splitter. A data packet and a select token are joined and
// the packet goes to one output FIFO, to all of them (broadcast), or is
// dropped and counted when the select names no output. Each output has its
// own circular FIFO, so a stalled consumer only blocks traffic aimed at it.
module split_n #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int DEPTH = 2,
  parameter int SELW  = $clog2(NOUT)
) (
  input  logic        clk,
  input  logic        rst_n,
  split_n_if.slave    bus,
  output logic        drop_pulse,
  output logic [15:0] drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [SELW:0]   NOUT_C  = (SELW + 1)'(NOUT);

  logic [WIDTH-1:0] mem_q    [NOUT][DEPTH];
  logic [PW-1:0]    wr_ptr_q [NOUT];
  logic [PW-1:0]    wr_ptr_d [NOUT];
  logic [PW-1:0]    rd_ptr_q [NOUT];
  logic [PW-1:0]    rd_ptr_d [NOUT];
  logic [CW-1:0]    cnt_q    [NOUT];
  logic [CW-1:0]    cnt_d    [NOUT];
  logic [WIDTH-1:0] last_q   [NOUT];
  logic [WIDTH-1:0] last_d   [NOUT];

  logic [NOUT-1:0]  has_space;
  logic [NOUT-1:0]  push;
  logic [NOUT-1:0]  pop;
  logic             sel_ok;
  logic             space;
  logic             fire;
  logic             drop;
  logic             drop_pulse_q;
  logic [15:0]      drop_cnt_q;
  logic [15:0]      drop_cnt_d;

  // Space per FIFO comes from the registered count only, so a full FIFO
  // being popped this cycle still refuses a write.
  always_comb begin
    has_space = '0;
    pop       = '0;
    for (int i = 0; i < NOUT; i++) begin
      has_space[i] = cnt_q[i] < DEPTH_C;
      pop[i]       = (cnt_q[i] != '0) && bus.r_ready[i];
    end
  end

  assign sel_ok = {1'b0, bus.s_sel} < NOUT_C;

  // Space needed for the offered token: one FIFO, all FIFOs, or none for a drop.
  always_comb begin
    space = 1'b0;
    if (bus.s_bcast)  space = &has_space;
    else if (sel_ok)  space = has_space[bus.s_sel];
    else              space = 1'b1;
  end

  assign fire        = rst_n & bus.l_valid & bus.s_valid & space;
  assign drop        = fire & ~bus.s_bcast & ~sel_ok;
  assign bus.l_ready = fire;
  assign bus.s_ready = fire;

  // Per-output write enables.
  always_comb begin
    push = '0;
    for (int i = 0; i < NOUT; i++) begin
      push[i] = fire & (bus.s_bcast | (sel_ok & (bus.s_sel == SELW'(i))));
    end
  end

  // FIFO pointer/count next state; last_d keeps the most recently popped
  // word so an emptied output keeps showing it.
  always_comb begin
    for (int i = 0; i < NOUT; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      last_d[i]   = last_q[i];
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        last_d[i]   = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

  // Output view: head of each non-empty FIFO, else the last word popped.
  always_comb begin
    bus.r_valid = '0;
    bus.r_data  = '0;
    for (int i = 0; i < NOUT; i++) begin
      bus.r_valid[i] = cnt_q[i] != '0;
      bus.r_data[i*WIDTH +: WIDTH] = (cnt_q[i] != '0) ? mem_q[i][rd_ptr_q[i]] : last_q[i];
    end
  end

  // Control state, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NOUT; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        last_q[i]   <= '0;
      end
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        last_q[i]   <= last_d[i];
      end
      drop_pulse_q <= drop;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Packet storage; contents only matter while the count covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NOUT; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.l_data;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_split_n.sv
// Bench for split_n: a 4-output instance driven from a vector table plus a
// scoreboard of per-output expected queues, and a 3-output instance used
// for invalid-select drops and counter saturation.
module tb_split_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  split_n_if #(.WIDTH(8), .NOUT(4)) if4 ();
  split_n_if #(.WIDTH(8), .NOUT(3)) if3 ();

  logic        dp4, dp3;
  logic [15:0] dc4, dc3;

  split_n #(.WIDTH(8), .NOUT(4), .DEPTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .drop_pulse(dp4), .drop_count(dc4));

  split_n #(.WIDTH(8), .NOUT(3), .DEPTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3), .drop_pulse(dp3), .drop_count(dc3));

  typedef struct {
    logic       lv;
    logic       sv;
    logic [1:0] sel;
    logic       bc;
    logic [7:0] data;
    logic [3:0] rr;
    logic       exp_lr;
    logic [3:0] exp_rv;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[4][$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_popped1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic lv, input logic sv, input logic [1:0] sel,
                              input logic bc, input logic [7:0] data, input logic [3:0] rr,
                              input logic lr, input logic [3:0] rv);
    vec_t v;
    v.lv = lv; v.sv = sv; v.sel = sel; v.bc = bc; v.data = data;
    v.rr = rr; v.exp_lr = lr; v.exp_rv = rv;
    return v;
  endfunction

  task automatic drive4(input vec_t v);
    if4.l_valid = v.lv;
    if4.s_valid = v.sv;
    if4.s_sel   = v.sel;
    if4.s_bcast = v.bc;
    if4.l_data  = v.data;
    if4.r_ready = v.rr;
  endtask

  task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] data, input logic [2:0] rr);
    if3.l_valid = v;
    if3.s_valid = v;
    if3.s_sel   = sel;
    if3.s_bcast = 1'b0;
    if3.l_data  = data;
    if3.r_ready = rr;
  endtask

  // Scoreboard step at mid-cycle: each non-empty expected queue must match
  // the output head; a ready consumer retires that head on the coming edge.
  task automatic sb_step4(input logic [3:0] rr);
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      if (exp_q[i].size() != 0) begin
        chk($sformatf("head%0d", i), 32'(if4.r_data[i*8 +: 8]), 32'(exp_q[i][0]));
        if (rr[i]) begin
          d = exp_q[i].pop_front();
          if (i == 1) n_popped1++;
        end
      end
    end
  endtask

  initial begin
    int         k;
    int         guard;
    logic [3:0] rr;
    logic       elr;

    // Vector table: lv sv sel bc data rr | expected l_ready, r_valid.
    vecs.push_back(mk(1,1,2,0,8'hA5,4'b0000, 1,4'b0000)); // first packet after reset
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0000, 0,4'b0100)); // one-cycle latency
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0100, 0,4'b0100)); // pop output 2
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,1,0,8'h3C,4'b0000, 0,4'b0000)); // data without select
    vecs.push_back(mk(1,1,1,0,8'h3C,4'b0000, 1,4'b0000)); // join completes
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0000, 0,4'b0010));
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0010, 0,4'b0010));
    vecs.push_back(mk(1,1,0,0,8'h01,4'b0000, 1,4'b0000)); // fill output 0
    vecs.push_back(mk(1,1,0,0,8'h02,4'b0000, 1,4'b0001));
    vecs.push_back(mk(1,1,0,0,8'h03,4'b0000, 0,4'b0001)); // output 0 full
    vecs.push_back(mk(1,1,3,0,8'h0D,4'b0000, 1,4'b0001)); // output 3 unaffected
    vecs.push_back(mk(1,1,0,0,8'h03,4'b0000, 0,4'b1001));
    vecs.push_back(mk(1,1,0,0,8'h03,4'b1001, 0,4'b1001)); // pop does not free space this cycle
    vecs.push_back(mk(1,1,0,0,8'h03,4'b0000, 1,4'b0001)); // third accepted next cycle
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0001, 0,4'b0001));
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0001, 0,4'b0001));
    vecs.push_back(mk(1,1,0,1,8'h77,4'b0000, 1,4'b0000)); // broadcast into empty FIFOs
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0000, 0,4'b1111));
    vecs.push_back(mk(0,0,0,0,8'h00,4'b1111, 0,4'b1111));
    vecs.push_back(mk(1,1,2,0,8'h21,4'b0000, 1,4'b0000)); // fill output 2
    vecs.push_back(mk(1,1,2,0,8'h22,4'b0000, 1,4'b0100));
    vecs.push_back(mk(1,1,0,1,8'h88,4'b0000, 0,4'b0100)); // broadcast blocked
    vecs.push_back(mk(1,1,0,1,8'h88,4'b0000, 0,4'b0100));
    vecs.push_back(mk(1,1,0,1,8'h88,4'b0100, 0,4'b0100)); // output 2 pops
    vecs.push_back(mk(1,1,0,1,8'h88,4'b0000, 1,4'b0100)); // broadcast goes
    vecs.push_back(mk(0,0,0,0,8'h00,4'b1111, 0,4'b1111));
    vecs.push_back(mk(0,0,0,0,8'h00,4'b1111, 0,4'b0100));
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0000, 0,4'b0000));
    vecs.push_back(mk(1,1,1,0,8'hA0,4'b0010, 1,4'b0000)); // streaming push+pop
    vecs.push_back(mk(1,1,1,0,8'hA1,4'b0010, 1,4'b0010));
    vecs.push_back(mk(1,1,1,0,8'hA2,4'b0010, 1,4'b0010));
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0010, 0,4'b0010));
    vecs.push_back(mk(0,0,0,0,8'h00,4'b0000, 0,4'b0000));

    // Reset held with both channels offered.
    drive4(mk(1,1,2,0,8'hFF,4'b1111, 0,4'b0000));
    drive3(1'b1, 2'd1, 8'hFF, 3'b111);
    repeat (2) @(negedge clk);
    chk("rst_lready4", 32'(if4.l_ready), 32'd0);
    chk("rst_sready4", 32'(if4.s_ready), 32'd0);
    chk("rst_rvalid4", 32'(if4.r_valid), 32'd0);
    chk("rst_rdata4",  32'(if4.r_data),  32'd0);
    chk("rst_lready3", 32'(if3.l_ready), 32'd0);
    chk("rst_rvalid3", 32'(if3.r_valid), 32'd0);
    chk("rst_dpulse",  32'(dp3), 32'd0);
    chk("rst_dcount",  32'(dc3), 32'd0);
    drive4(mk(0,0,0,0,8'h00,4'b0000, 0,4'b0000));
    drive3(1'b0, 2'd0, 8'h00, 3'b000);
    rst_n = 1'b1;

    // Table-driven phase.
    for (int v = 0; v < vecs.size(); v++) begin
      @(posedge clk); #1;
      drive4(vecs[v]);
      @(negedge clk);
      chk($sformatf("lready_v%0d", v), 32'(if4.l_ready), 32'(vecs[v].exp_lr));
      chk($sformatf("sready_v%0d", v), 32'(if4.s_ready), 32'(vecs[v].exp_lr));
      chk($sformatf("rvalid_v%0d", v), 32'(if4.r_valid), 32'(vecs[v].exp_rv));
      sb_step4(vecs[v].rr);
      if (vecs[v].exp_lr) begin
        if (vecs[v].bc) for (int i = 0; i < 4; i++) exp_q[i].push_back(vecs[v].data);
        else exp_q[vecs[v].sel].push_back(vecs[v].data);
      end
    end
    chk("table_leftover", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'd0);

    // Reset in mid-operation discards buffered packets.
    @(posedge clk); #1;
    drive4(mk(1,1,0,0,8'h55,4'b0000, 0,4'b0000));
    @(posedge clk); #1;
    drive4(mk(1,1,1,0,8'h66,4'b0000, 0,4'b0000));
    @(posedge clk); #1;
    drive4(mk(1,1,2,0,8'h67,4'b0000, 0,4'b0000));
    @(negedge clk);
    chk("pre_rst_rvalid", 32'(if4.r_valid), 32'b0011);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(if4.r_valid), 32'd0);
    chk("mid_rst_lready", 32'(if4.l_ready), 32'd0);
    @(negedge clk);
    drive4(mk(0,0,0,0,8'h00,4'b0000, 0,4'b0000));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(if4.r_valid), 32'd0);

    // Wrap: 20 packets to output 1 with a randomly toggled consumer.
    k = 0;
    guard = 0;
    n_popped1 = 0;
    while (k < 20 && guard < 400) begin
      @(posedge clk); #1;
      rr = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
      drive4(mk(1,1,1,0,8'(k),rr, 0,4'b0000));
      @(negedge clk);
      elr = exp_q[1].size() < 2;
      chk("wrap_lready", 32'(if4.l_ready), 32'(elr));
      chk("wrap_rvalid", 32'(if4.r_valid), 32'({2'b00, exp_q[1].size() != 0, 1'b0}));
      sb_step4(rr);
      if (elr) begin
        exp_q[1].push_back(8'(k));
        k++;
      end
      guard++;
    end
    chk("wrap_sent", 32'(k), 32'd20);
    guard = 0;
    while (exp_q[1].size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      drive4(mk(0,0,0,0,8'h00,4'b0010, 0,4'b0000));
      @(negedge clk);
      sb_step4(4'b0010);
      guard++;
    end
    chk("wrap_popped", 32'(n_popped1), 32'd20);
    @(posedge clk); #1;
    drive4(mk(0,0,0,0,8'h00,4'b0000, 0,4'b0000));
    @(negedge clk);
    chk("wrap_empty", 32'(if4.r_valid), 32'd0);
    chk("no_drop4", 32'(dc4), 32'd0);

    // Invalid select on the 3-output instance.
    @(posedge clk); #1;
    drive3(1'b1, 2'd3, 8'hEE, 3'b000);
    @(negedge clk);
    chk("drop_lready", 32'(if3.l_ready), 32'd1);
    chk("drop_sready", 32'(if3.s_ready), 32'd1);
    chk("drop_pulse_early", 32'(dp3), 32'd0);
    @(posedge clk); #1;
    drive3(1'b0, 2'd0, 8'h00, 3'b000);
    @(negedge clk);
    chk("drop_pulse1", 32'(dp3), 32'd1);
    chk("drop_count1", 32'(dc3), 32'd1);
    chk("drop_rvalid", 32'(if3.r_valid), 32'd0);
    @(negedge clk);
    chk("drop_pulse_end", 32'(dp3), 32'd0);
    chk("drop_count_hold", 32'(dc3), 32'd1);

    // Valid unicast on the 3-output instance.
    @(posedge clk); #1;
    drive3(1'b1, 2'd1, 8'h5A, 3'b000);
    @(negedge clk);
    chk("u3_lready", 32'(if3.l_ready), 32'd1);
    @(posedge clk); #1;
    drive3(1'b0, 2'd0, 8'h00, 3'b010);
    @(negedge clk);
    chk("u3_rvalid", 32'(if3.r_valid), 32'b010);
    chk("u3_rdata", 32'(if3.r_data[15:8]), 32'h5A);
    chk("u3_nodrop", 32'(dp3), 32'd0);
    @(negedge clk);
    chk("u3_popped", 32'(if3.r_valid), 32'd0);
    chk("u3_hold_data", 32'(if3.r_data[15:8]), 32'h5A);

    // Back-to-back drops up to 16'hFFFE, then saturation.
    @(posedge clk); #1;
    if3.r_ready = 3'b000;
    drive3(1'b1, 2'd3, 8'h11, 3'b000);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_pulse1", 32'(dp3), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_pulse2", 32'(dp3), 32'd1);
    chk("b2b_count", 32'(dc3), 32'd3);
    repeat (65531) @(posedge clk);
    #1;
    drive3(1'b0, 2'd0, 8'h00, 3'b000);
    @(negedge clk);
    chk("sat_fffe", 32'(dc3), 32'hFFFE);
    chk("sat_pulse", 32'(dp3), 32'd1);
    @(posedge clk); #1;
    drive3(1'b1, 2'd3, 8'h12, 3'b000);
    @(negedge clk);
    chk("sat_pre", 32'(dc3), 32'hFFFE);
    @(posedge clk);
    @(negedge clk);
    chk("sat_ffff", 32'(dc3), 32'hFFFF);
    @(posedge clk); #1;
    drive3(1'b0, 2'd0, 8'h00, 3'b000);
    @(negedge clk);
    chk("sat_stay", 32'(dc3), 32'hFFFF);
    chk("sat_pulse2", 32'(dp3), 32'd1);
    @(negedge clk);
    chk("sat_pulse_end", 32'(dp3), 32'd0);
    chk("sat_final", 32'(dc3), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
